// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner tags and
// the latched transaction record.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xact_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side request/response bus; the arbiter is the master, memory the slave.
interface mem_arbiter_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Saturating response-wait timer; expired holds once LIMIT cycles have been counted.
module mem_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(LIMIT));
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter with LSU priority,
// IFU anti-starvation and a response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LSU_STREAK_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_ready_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wstrb_i,
    output logic        lsu_ready_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    mem_arbiter_if.master mem
);
    localparam int SW = $clog2(LSU_STREAK_MAX + 1);

    arb_state_t  state, state_nxt;
    xact_t       xact;
    logic [SW-1:0] streak;
    logic        lsu_win, ifu_win, lsu_hs, ifu_hs;
    logic        in_req, expired;
    logic        rsp_real, rsp_err, rsp_valid;
    logic [31:0] rsp_data;

    // LSU wins unless the IFU has been passed over LSU_STREAK_MAX times in a row.
    assign lsu_win     = lsu_req_i && !(ifu_req_i && streak == SW'(LSU_STREAK_MAX));
    assign ifu_win     = ifu_req_i && !lsu_win;
    assign lsu_ready_o = !reset && state == ST_IDLE && lsu_win;
    assign ifu_ready_o = !reset && state == ST_IDLE && ifu_win;
    assign lsu_hs      = lsu_req_i && lsu_ready_o;
    assign ifu_hs      = ifu_req_i && ifu_ready_o;

    always_ff @(posedge clock) begin
        if (reset)
            streak <= '0;
        else if (state == ST_IDLE) begin
            if (!ifu_req_i || ifu_hs)
                streak <= '0;
            else if (lsu_hs && streak != SW'(LSU_STREAK_MAX))
                streak <= streak + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            xact <= '0;
        else if (lsu_hs)
            xact <= '{owner: OWN_LSU, we: lsu_we_i, addr: lsu_addr_i,
                      wdata: lsu_wdata_i, wstrb: lsu_wstrb_i};
        else if (ifu_hs)
            xact <= '{owner: OWN_IFU, we: 1'b0, addr: ifu_addr_i,
                      wdata: 32'h0, wstrb: 4'h0};
    end

    mem_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expired(expired)
    );

    // A real response always beats the timeout in the same cycle.
    assign rsp_real  = !reset && mem.mem_rvalid_i &&
                       ((state == ST_REQ && mem.mem_ready_i) || state == ST_WAIT);
    assign rsp_err   = !reset && state == ST_WAIT && expired && !mem.mem_rvalid_i;
    assign rsp_valid = rsp_real || rsp_err;
    assign rsp_data  = rsp_real ? mem.mem_rdata_i : 32'h0;

    assign ifu_rvalid_o = rsp_valid && xact.owner == OWN_IFU;
    assign ifu_rdata_o  = ifu_rvalid_o ? rsp_data : 32'h0;
    assign ifu_err_o    = rsp_err && xact.owner == OWN_IFU;
    assign lsu_rvalid_o = rsp_valid && xact.owner == OWN_LSU;
    assign lsu_rdata_o  = lsu_rvalid_o ? rsp_data : 32'h0;
    assign lsu_err_o    = rsp_err && xact.owner == OWN_LSU;

    assign in_req          = !reset && state == ST_REQ;
    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req && xact.we;
    assign mem.mem_addr_o  = in_req ? xact.addr  : 32'h0;
    assign mem.mem_wdata_o = in_req ? xact.wdata : 32'h0;
    assign mem.mem_wstrb_o = in_req ? xact.wstrb : 4'h0;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (lsu_hs || ifu_hs) state_nxt = ST_REQ;
            ST_REQ:  if (mem.mem_ready_i)  state_nxt = rsp_real ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (rsp_valid)        state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end
endmodule
